// File: rtl/adder_pkg.sv
// Shared definitions for the sliced, pipelined add/subtract unit.
// Stage count, configuration check and the one-bit full-adder cell.
package adder_pkg;

  function automatic int stages(int width, int chunk);
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(int width, int chunk);
    return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
  endfunction

  // {carry, sum} of one full-adder cell
  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic c
  );
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operation/result handshake bundle of the pipelined adder.
// master drives operations and accepts results; slave is the unit.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder made of full-adder cells.
// c_msb is the carry into the top bit, used for signed overflow.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin : p_rip
        logic       c;
        logic [1:0] r;
        c     = ci;
        r     = '0;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb = c;
            r     = fa(x[i], y[i], c);
            s[i]  = r[0];
            c     = r[1];
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, registered carries,
// operand skew and sum deskew registers, whole-pipe stall on out_ready.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave io
);

    localparam int S = stages(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             adv;
    logic             c0;
    logic [WIDTH-1:0] beff;

    logic [WIDTH-1:0] ain [S];
    logic [WIDTH-1:0] bin [S];
    logic [WIDTH-1:0] sin [S];
    logic             vin [S];
    logic             sci [S];
    logic [CHUNK-1:0] ss  [S];
    logic             sco [S];
    logic             scm [S];

    logic [WIDTH-1:0] a_q [S];
    logic [WIDTH-1:0] b_q [S];
    logic [WIDTH-1:0] s_q [S];
    logic             v_q [S];
    logic             c_q [S];
    logic             ovf_q;

    assign adv         = io.out_ready;
    assign io.in_ready = adv;
    assign beff        = io.sub ? ~io.b : io.b;
    assign c0          = io.sub | io.cin;

    for (genvar k = 0; k < S; k++) begin : g_st
        if (k == 0) begin : g_in
            assign ain[k] = io.a;
            assign bin[k] = beff;
            assign sin[k] = '0;
            assign vin[k] = io.in_valid;
            assign sci[k] = c0;
        end else begin : g_in
            assign ain[k] = a_q[k-1];
            assign bin[k] = b_q[k-1];
            assign sin[k] = s_q[k-1];
            assign vin[k] = v_q[k-1];
            assign sci[k] = c_q[k-1];
        end

        chunk_adder #(
            .CHUNK(CHUNK)
        ) u_add (
            .x    (ain[k][k*CHUNK +: CHUNK]),
            .y    (bin[k][k*CHUNK +: CHUNK]),
            .ci   (sci[k]),
            .s    (ss[k]),
            .co   (sco[k]),
            .c_msb(scm[k])
        );
    end

    // Each stage keeps only the slices it owns: operands above, sums at/below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < S; k++) begin
                v_q[k] <= vin[k];
                if (vin[k]) begin
                    c_q[k] <= sco[k];
                    for (int j = 0; j < S; j++) begin
                        if (j > k) begin
                            a_q[k][j*CHUNK +: CHUNK] <= ain[k][j*CHUNK +: CHUNK];
                            b_q[k][j*CHUNK +: CHUNK] <= bin[k][j*CHUNK +: CHUNK];
                        end else if (j < k) begin
                            s_q[k][j*CHUNK +: CHUNK] <= sin[k][j*CHUNK +: CHUNK];
                        end else begin
                            s_q[k][j*CHUNK +: CHUNK] <= ss[k];
                        end
                    end
                end
            end
            if (vin[S-1]) ovf_q <= scm[S-1] ^ sco[S-1];
        end
    end

    // Top stage has no slices above it, so its operand registers stay idle.
    logic unused_skew;
    assign unused_skew = ^{a_q[S-1], b_q[S-1]};

    assign io.out_valid = v_q[S-1];
    assign io.sum       = s_q[S-1];
    assign io.cout      = c_q[S-1];
    assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16/4 pipe plus an 8/8 single stage.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    pipelined_adder_if #(.WIDTH(16)) io ();
    pipelined_adder_if #(.WIDTH(8))  io8 ();

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io.slave)
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io8.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        io.in_valid = v;
        io.a        = a;
        io.b        = b;
        io.cin      = cin;
        io.sub      = sub;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        io.out_ready  = 1'b1;
        io8.out_ready = 1'b1;
        drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        io8.in_valid = 1'b1;
        io8.a        = 8'($urandom);
        io8.b        = 8'($urandom);
        io8.cin      = 1'($urandom);
        io8.sub      = 1'($urandom);
        step();
        step();
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== 19'h0) begin
            n_err++;
            $display("FAIL reset16: got v=%0b sum=%h c=%0b o=%0b want all 0",
                     io.out_valid, io.sum, io.cout, io.ovf);
        end
        n_vec++;
        if ({io8.out_valid, io8.sum, io8.cout, io8.ovf} !== 11'h0) begin
            n_err++;
            $display("FAIL reset8: got v=%0b sum=%h c=%0b o=%0b want all 0",
                     io8.out_valid, io8.sum, io8.cout, io8.ovf);
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        io8.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (io.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: out_valid=%0b want 0", i, io.out_valid);
            end
        end
    endtask

    task automatic test_add_carry();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        n_vec++;
        if (io.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_carry_early: out_valid=%0b want 0", io.out_valid);
        end
        step();
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_carry: got v=%0b sum=%h c=%0b o=%0b want v=1 sum=0000 c=1 o=0",
                     io.out_valid, io.sum, io.cout, io.ovf);
        end
        step();
    endtask

    task automatic test_sub_ovf();
        drive(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) step();
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sub_ovf: got v=%0b sum=%h c=%0b o=%0b want v=1 sum=7fff c=1 o=1",
                     io.out_valid, io.sum, io.cout, io.ovf);
        end
        step();
    endtask

    task automatic test_sub_borrow();
        drive(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) step();
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got v=%0b sum=%h c=%0b o=%0b want v=1 sum=fffe c=0 o=0",
                     io.out_valid, io.sum, io.cout, io.ovf);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa    [6];
        logic [15:0] ob    [6];
        logic        oc    [6];
        logic        os    [6];
        logic [17:0] exp_r [6];
        int          issued;
        int          got;
        logic        rdy;
        oa    = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hABCD, 16'h8000};
        ob    = '{16'h1111, 16'h0001, 16'h0000, 16'h0001, 16'h1234, 16'h8000};
        oc    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        os    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_r = '{{16'h2345, 2'b00}, {16'h8000, 2'b01}, {16'h0000, 2'b10},
                  {16'hFFFF, 2'b00}, {16'hBE01, 2'b00}, {16'h0000, 2'b11}};
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            rdy = !(cyc >= 5 && cyc <= 7);
            io.out_ready = rdy;
            if (issued < 6) drive(1'b1, oa[issued], ob[issued], oc[issued], os[issued]);
            else            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #1;
            if (!rdy) begin
                n_vec++;
                if (io.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_in_ready cyc %0d: in_ready=%0b want 0", cyc, io.in_ready);
                end
            end
            if (io.out_valid === 1'b1) begin
                n_vec++;
                if ({io.sum, io.cout, io.ovf} !== exp_r[got]) begin
                    n_err++;
                    $display("FAIL b2b_result %0d cyc %0d: got sum=%h c=%0b o=%0b want sum=%h c=%0b o=%0b",
                             got, cyc, io.sum, io.cout, io.ovf,
                             exp_r[got][17:2], exp_r[got][1], exp_r[got][0]);
                end
                if (rdy) got++;
            end
            if (rdy && issued < 6) issued++;
            @(posedge clk);
            #1;
        end
        io.out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n_vec++;
        if (got != 6) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 6", got);
        end
    endtask

    task automatic test_reset_midflight();
        io.out_ready = 1'b1;
        drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midflight_pre: got v=%0b sum=%h want v=1 sum=0003",
                     io.out_valid, io.sum);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({io.out_valid, io.sum, io.cout, io.ovf} !== 19'h0) begin
            n_err++;
            $display("FAIL midflight_rst: got v=%0b sum=%h c=%0b o=%0b want all 0",
                     io.out_valid, io.sum, io.cout, io.ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (io.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midflight_stale cyc %0d: out_valid=%0b sum=%h want out_valid 0",
                         i, io.out_valid, io.sum);
            end
        end
    endtask

    task automatic test_single_stage();
        io8.out_ready = 1'b1;
        io8.in_valid  = 1'b1;
        io8.a         = 8'h7F;
        io8.b         = 8'h01;
        io8.cin       = 1'b0;
        io8.sub       = 1'b0;
        step();
        io8.a   = 8'hFF;
        io8.b   = 8'h01;
        io8.sub = 1'b1;
        n_vec++;
        if ({io8.out_valid, io8.sum, io8.cout, io8.ovf} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_add: got v=%0b sum=%h c=%0b o=%0b want v=1 sum=80 c=0 o=1",
                     io8.out_valid, io8.sum, io8.cout, io8.ovf);
        end
        step();
        io8.in_valid = 1'b0;
        n_vec++;
        if ({io8.out_valid, io8.sum, io8.cout, io8.ovf} !== {1'b1, 8'hFE, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_sub: got v=%0b sum=%h c=%0b o=%0b want v=1 sum=fe c=1 o=0",
                     io8.out_valid, io8.sum, io8.cout, io8.ovf);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_ovf();
        test_sub_borrow();
        test_back_to_back();
        test_reset_midflight();
        test_single_stage();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
